// File: rtl/alu_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_control_unit                                                   |
// | Decodes instructions, reads operands, drives a 32-bit ALU, waits   |
// | ALU_WAIT cycles, then writes the result and flags back.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_control_unit #(
  parameter int NUM_REGS = 8,
  parameter int ALU_WAIT = 1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] instr,
  input  logic        instrValid,
  output logic        instrReady,
  output logic [31:0] aluA,
  output logic [31:0] aluB,
  output logic [5:0]  aluOpCode,
  output logic        aluCOptional,
  input  logic [31:0] aluAns,
  input  logic        aluAnsOptional,
  input  logic        aluZ,
  input  logic        aluN,
  input  logic [2:0]  rdAddr,
  output logic [31:0] rdData,
  output logic        done,
  output logic        illegal,
  output logic        flagC,
  output logic        flagZ,
  output logic        flagN
);

  localparam logic [3:0] C_ALU_WAIT = 4'(ALU_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic        alu_cin_q, alu_cin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        res_c_q, res_c_d;
  logic        res_z_q, res_z_d;
  logic        res_n_q, res_n_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_n_q, flag_n_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [5:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic        w_with_carry;
  logic        w_use_imm;
  logic [31:0] w_imm;
  logic        w_is_alu;
  logic        w_is_arith;
  logic        w_is_illegal;

  assign w_op         = instr_q[31:26];
  assign w_rd         = instr_q[25:23];
  assign w_rs1        = instr_q[22:20];
  assign w_rs2        = instr_q[19:17];
  assign w_with_carry = instr_q[16];
  assign w_use_imm    = instr_q[15];
  assign w_imm        = {17'd0, instr_q[14:0]};
  assign w_is_alu     = (w_op[5:4] != 2'b00);
  assign w_is_arith   = (w_op[5:4] == 2'b01);
  assign w_is_illegal = (w_op[5:4] == 2'b00) && (w_op[3:0] != 4'd0);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_c_d   = res_c_q;
    res_z_d   = res_z_q;
    res_n_d   = res_n_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    regs_d    = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (instrValid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_is_alu) begin
          alu_a_d   = regs_q[w_rs1];
          alu_b_d   = w_use_imm ? w_imm : regs_q[w_rs2];
          alu_op_d  = w_op;
          alu_cin_d = w_with_carry & flag_c_q;
          cnt_d     = C_ALU_WAIT;
          state_d   = ST_EXEC;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        // Sample on the edge where the counter reaches zero.
        if (cnt_q <= 4'd1) begin
          res_d   = aluAns;
          res_c_d = aluAnsOptional;
          res_z_d = aluZ;
          res_n_d = aluN;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (w_is_alu) begin
          if (w_rd != 3'd0) begin
            regs_d[w_rd] = res_q;
          end
          flag_z_d = res_z_q;
          flag_n_d = res_n_q;
          if (w_is_arith) begin
            flag_c_d = res_c_q;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_c_q   <= 1'b0;
      res_z_q   <= 1'b0;
      res_n_q   <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_c_q   <= res_c_d;
      res_z_q   <= res_z_d;
      res_n_q   <= res_n_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      regs_q    <= regs_d;
    end
  end

  assign instrReady   = (state_q == ST_IDLE);
  assign done         = (state_q == ST_WB);
  assign illegal      = (state_q == ST_WB) && w_is_illegal;
  assign aluA         = alu_a_q;
  assign aluB         = alu_b_q;
  assign aluOpCode    = alu_op_q;
  assign aluCOptional = alu_cin_q;
  assign rdData       = regs_q[rdAddr];
  assign flagC        = flag_c_q;
  assign flagZ        = flag_z_q;
  assign flagN        = flag_n_q;

endmodule
`default_nettype wire

// File: doc/alu_control_unit.md
# alu_control_unit

Sequencing control unit that issues work to the 32-bit ALU and consumes its results: the driving end of the ALU's opCode/operand/result interface. It accepts 32-bit instructions over a valid/ready handshake, decodes them, reads operands from a small internal register file, and drives the ALU's `a`, `b`, `opCode` and `cOptional` inputs. It holds those inputs while the ALU settles, then writes `ans` back and updates the C/Z/N flags. It sits between the instruction source (bench or fetch logic) and the ALU instance.

## Interface
- `NUM_REGS`, 8: register-file depth; `r0` reads 0 and ignores writes; address field is 3 bits.
- `ALU_WAIT`, 1: cycles operands are held before the ALU result is sampled; legal range 1..15.
- `clk` in 1: single clock, all state on rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction word, fields listed under Operation.
- `instrValid` in 1: `instr` is valid.
- `instrReady` out 1: high only in IDLE.
- `aluA` out 32: registered; drives ALU `a`.
- `aluB` out 32: registered; drives ALU `b`.
- `aluOpCode` out 6: registered; drives ALU `opCode`.
- `aluCOptional` out 1: registered; drives ALU `cOptional`.
- `aluAns` in 32: ALU `ans`.
- `aluAnsOptional` in 1: ALU carry/borrow out.
- `aluZ` in 1: ALU zero flag.
- `aluN` in 1: ALU negative flag.
- `rdAddr` in 3: debug register read address.
- `rdData` out 32: combinational read of `regs[rdAddr]`.
- `done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: pulses together with `done` for an illegal opcode.
- `flagC`, `flagZ`, `flagN` out 1 each: architectural flags.

## Operation
- **Instruction fields**
  - [31:26] opCode, [25:23] rd, [22:20] rs1, [19:17] rs2.
  - [16] withCarry, [15] useImm, [14:0] imm (zero-extended to 32 bits).
- **Opcode classes**
  - 01xxxx arithmetic (010000 add, 010001 sub).
  - 10xxxx relational.
  - 11xxxx shift.
  - 000000 NOP.
  - Any other 00xxxx is illegal.
  - Undefined codes inside classes 01/10/11 are passed to the ALU unchanged and retired normally.
- **FSM: IDLE → DECODE → EXEC → WB → IDLE**
  - **IDLE:** `instrReady`=1. Handshake `instrValid && instrReady` latches `instr` and moves to DECODE.
  - **DECODE:**
    - ALU class: load `aluA`=regs[rs1]; `aluB`=useImm ? imm : regs[rs2]; `aluOpCode`=opCode; `aluCOptional`=withCarry & flagC. Load the wait counter with ALU_WAIT; go to EXEC.
    - NOP or illegal: go straight to WB; ALU outputs are unchanged.
  - **EXEC:** decrement the counter each cycle. When it reaches 0, capture `aluAns`, `aluAnsOptional`, `aluZ`, `aluN` into internal registers and go to WB.
  - **WB:** `done`=1.
    - ALU class: write the captured ans to rd at the end of the cycle (dropped if rd=0). Z and N are updated from the captured values. C is updated from the captured ansOptional only for class 01; other classes leave C unchanged.
    - NOP/illegal: no register or flag change; `illegal`=1 for illegal.
    - Go to IDLE.
- ALU outputs hold their last values outside DECODE; the ALU is never re-driven mid-instruction.
- **Reset** (asynchronous, any state, including mid-instruction):
  - state IDLE; all registers 0.
  - flags 0.
  - `aluA`/`aluB` 0, `aluOpCode` 000000, `aluCOptional` 0.
  - `done`/`illegal` 0.
  - The in-flight instruction is abandoned with no writeback and no `done`.
- `instrReady` is 1 from the first cycle after `rstN` deassertion.

## Timing
- Accepting edge = E0.
- **ALU-class instruction**
  - ALU inputs valid after E0+1.
  - Result sampled at E0+1+ALU_WAIT.
  - `done` high in the cycle after edge E0+1+ALU_WAIT.
  - Register and flags updated at E0+2+ALU_WAIT; `rdData` shows the new value from then on.
- **NOP/illegal:** `done` (and `illegal`) high in the cycle after E0+1.
- **Back-to-back:** with `instrValid` held high, one ALU instruction is accepted every ALU_WAIT+3 cycles and one NOP every 3 cycles.
- **Operand dependency:** an instruction always sees the previous instruction's writeback, because writeback completes before IDLE. No hazard logic is needed.
- **Valid without ready:** `instrValid` while not ready is ignored; the source must hold `instr` until the handshake.
- **Same-cycle debug read:** `rdData` during WB shows the old value.

## Test plan
- **Reset:** pulse `rstN` low → `instrReady`=1, flags 0, `rdData`=0 for all addresses, `aluOpCode`=000000, `done`=0.
- **Add immediate (ALU_WAIT=1):** bench ALU model; add r1=r0+imm 5 (opCode 010000, useImm=1) → `aluA`=0, `aluB`=5 one cycle after accept; `done` two cycles after accept; r1=5, Z=0, N=0, C=0.
- **Subtract to zero, then negative:**
  - sub r2=r1−imm 5 → r2=0, Z=1.
  - sub r3=r0−imm 1 → r3=0xFFFFFFFF, N=1, C=model borrow 1.
  - Then add with withCarry=1 → `aluCOptional`=1 during EXEC.
- **NOP and illegal:**
  - opCode 000000 → `done` one cycle after accept, `illegal`=0.
  - opCode 000011 → `done`=`illegal`=1 one cycle after accept; registers and flags unchanged.
  - Write to rd=0 → r0 still reads 0.
- **Throughput and wait:** ALU_WAIT=3 with `instrValid` held high for 3 adds → accepts every 6 cycles; `aluA`/`aluB` stable for all 3 EXEC cycles; dependent add reads the updated register.
- **Mid-operation reset:** assert `rstN` low during EXEC → no `done`, all registers and flags 0, `instrReady`=1 after release.
